regfile_sb: RTL and testbench

- Parametrised general-purpose register file for the pipelined CPU datapath.
- Two read ports and one write port, with per-byte write enables and optional write-to-read bypass.
- Register 0 can be hardwired to zero.
- An integrated pending-write scoreboard lets the hazard unit stall on operands whose producer has issued but not yet written back.

---
 rtl/regfile_sb.sv | 94 +++++++++
 tb/tb_regfile_sb.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Parametrised 2R/1W register file with byte enables, optional write bypass,
// hardwired zero register and a pending-write scoreboard for hazard stalls.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   ra1,
  input  logic [ADDR_W-1:0]   ra2,
  output logic [DATA_W-1:0]   rd1,
  output logic [DATA_W-1:0]   rd2,
  output logic                rd1_busy,
  output logic                rd2_busy,
  input  logic                we,
  input  logic [ADDR_W-1:0]   wa,
  input  logic [DATA_W-1:0]   wd,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic                sb_set,
  input  logic [ADDR_W-1:0]   sb_addr,
  output logic [ADDR_W:0]     pend_cnt
);

  localparam int DEPTH  = 2**ADDR_W;
  localparam int NBYTES = DATA_W/8;
  localparam bit BP     = (BYPASS != 0);
  localparam bit ZR     = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_next;
  logic [DATA_W-1:0] wr_merged;
  logic              wr_hit;
  logic              set_hit;
  logic              cnt_inc;
  logic              cnt_dec;

  assign wr_hit  = we && !(ZR && (wa == '0));
  assign set_hit = sb_set && !(ZR && (sb_addr == '0));

  // Byte-merged write word; also the forwarded value on a bypass hit.
  always_comb begin
    wr_merged = regs[wa];
    for (int k = 0; k < NBYTES; k++) begin
      if (wbe[k]) wr_merged[8*k +: 8] = wd[8*k +: 8];
    end
  end

  always_comb begin
    rd1 = regs[ra1];
    if (BP && wr_hit && (wa == ra1)) rd1 = wr_merged;
    if ((ZR && (ra1 == '0)) || !reset) rd1 = '0;
    rd2 = regs[ra2];
    if (BP && wr_hit && (wa == ra2)) rd2 = wr_merged;
    if ((ZR && (ra2 == '0)) || !reset) rd2 = '0;
  end

  // A bypassed operand is valid this cycle, so its busy flag drops immediately.
  always_comb begin
    rd1_busy = pend[ra1] & ~(BP & we & (wa == ra1)) & reset;
    rd2_busy = pend[ra2] & ~(BP & we & (wa == ra2)) & reset;
  end

  // Set beats clear on the same address: a new producer has just issued.
  always_comb begin
    pend_next = pend;
    if (we) pend_next[wa] = 1'b0;
    if (set_hit) pend_next[sb_addr] = 1'b1;
    if (ZR) pend_next[0] = 1'b0;
    cnt_inc = set_hit && !pend[sb_addr];
    cnt_dec = we && pend[wa] && !(set_hit && (sb_addr == wa));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[wa] <= wr_merged;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_next;
      pend_cnt <= pend_cnt + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a bypassing and a non-bypassing instance share
// all inputs so forwarding differences can be checked side by side.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ra1, ra2, wa, sb_addr;
  logic        we, sb_set;
  logic [31:0] wd;
  logic [3:0]  wbe;
  logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
  logic        rd1_busy, rd2_busy, nb_rd1_busy, nb_rd2_busy;
  logic [5:0]  pend_cnt, nb_pend_cnt;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .rd1_busy(rd1_busy), .rd2_busy(rd2_busy), .we(we), .wa(wa), .wd(wd),
    .wbe(wbe), .sb_set(sb_set), .sb_addr(sb_addr), .pend_cnt(pend_cnt)
  );

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(nb_rd1), .rd2(nb_rd2),
    .rd1_busy(nb_rd1_busy), .rd2_busy(nb_rd2_busy), .we(we), .wa(wa), .wd(wd),
    .wbe(wbe), .sb_set(sb_set), .sb_addr(sb_addr), .pend_cnt(nb_pend_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [4:0] a, input logic [31:0] d,
                               input logic [3:0] be, input logic s, input logic [4:0] sa);
    we = w; wa = a; wd = d; wbe = be; sb_set = s; sb_addr = sa;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    reset = 1'b0; ra1 = 5'd3; ra2 = 5'd0;
    applyStimulus(1'b1, 5'd3, 32'hDEADBEEF, 4'hF, 1'b0, 5'd0);
    step(); step();
    checkOutput("reset_rd1", rd1, 32'h0);
    checkOutput("reset_cnt", 32'(pend_cnt), 32'h0);
    checkOutput("reset_busy", 32'(rd1_busy), 32'h0);
    @(negedge clk); reset = 1'b1;
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    checkOutput("first_write", rd1, 32'hDEADBEEF);

    applyStimulus(1'b1, 5'd5, 32'h11223344, 4'hF, 1'b0, 5'd0);
    step();
    ra1 = 5'd5; ra2 = 5'd5;
    applyStimulus(1'b1, 5'd5, 32'hAABBCCDD, 4'b0101, 1'b0, 5'd0);
    checkOutput("bypass_rd1", rd1, 32'h11BB33DD);
    checkOutput("bypass_rd2", rd2, 32'h11BB33DD);
    checkOutput("nobypass_rd1", nb_rd1, 32'h11223344);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    checkOutput("merged_rd1", rd1, 32'h11BB33DD);
    checkOutput("nb_merged_rd1", nb_rd1, 32'h11BB33DD);

    ra1 = 5'd0;
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b1, 5'd0);
    checkOutput("zero_rd1_pre", rd1, 32'h0);
    step();
    checkOutput("zero_rd1_post", rd1, 32'h0);
    checkOutput("zero_busy", 32'(rd1_busy), 32'h0);
    checkOutput("zero_cnt", 32'(pend_cnt), 32'h0);

    ra2 = 5'd7;
    applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd7);
    checkOutput("set_busy_sameCycle", 32'(rd2_busy), 32'h0);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    checkOutput("set7_cnt", 32'(pend_cnt), 32'h1);
    checkOutput("set7_busy", 32'(rd2_busy), 32'h1);
    applyStimulus(1'b1, 5'd7, 32'h00000077, 4'hF, 1'b0, 5'd0);
    checkOutput("wb7_busy_bypass", 32'(rd2_busy), 32'h0);
    checkOutput("wb7_busy_nobypass", 32'(nb_rd2_busy), 32'h1);
    checkOutput("wb7_rd2", rd2, 32'h00000077);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    checkOutput("wb7_cnt", 32'(pend_cnt), 32'h0);
    applyStimulus(1'b1, 5'd7, 32'h00000088, 4'hF, 1'b1, 5'd7);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    checkOutput("setwins_cnt", 32'(pend_cnt), 32'h1);
    checkOutput("setwins_busy", 32'(rd2_busy), 32'h1);
    applyStimulus(1'b1, 5'd7, 32'h0, 4'h0, 1'b0, 5'd0);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    checkOutput("clear7_cnt", 32'(pend_cnt), 32'h0);

    for (int a = 1; a < 32; a++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'(a));
      step();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    checkOutput("full_cnt", 32'(pend_cnt), 32'd31);
    applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd9);
    step();
    checkOutput("dup_set_cnt", 32'(pend_cnt), 32'd31);
    for (int a = 1; a < 32; a++) begin
      applyStimulus(1'b1, 5'(a), 32'hFFFFFFFF, 4'h0, 1'b0, 5'd0);
      step();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    checkOutput("drain_cnt", 32'(pend_cnt), 32'd0);
    ra1 = 5'd5;
    #1;
    checkOutput("wbe0_nodata", rd1, 32'h11BB33DD);
    applyStimulus(1'b1, 5'd4, 32'h0, 4'h0, 1'b0, 5'd0);
    step();
    checkOutput("no_underflow", 32'(pend_cnt), 32'd0);

    applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd10);
    step();
    applyStimulus(1'b1, 5'd10, 32'h0, 4'h0, 1'b1, 5'd11);
    step();
    checkOutput("net_zero_cnt", 32'(pend_cnt), 32'd1);
    for (int a = 12; a < 15; a++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'(a));
      step();
    end
    checkOutput("pre_reset_cnt", 32'(pend_cnt), 32'd4);

    ra1 = 5'd3; ra2 = 5'd12;
    applyStimulus(1'b1, 5'd3, 32'h12345678, 4'hF, 1'b1, 5'd20);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_rd1", rd1, 32'h0);
    checkOutput("async_busy", 32'(rd2_busy), 32'h0);
    checkOutput("async_cnt", 32'(pend_cnt), 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    @(negedge clk); reset = 1'b1;
    step();
    checkOutput("post_reset_reg3", rd1, 32'h0);
    ra1 = 5'd5;
    #1;
    checkOutput("post_reset_reg5", rd1, 32'h0);
    checkOutput("post_reset_busy", 32'(rd2_busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
